// File: rtl/alu_disp_scan.sv
// Seven-segment scanner for the ALU wrapper outputs: 8-digit common-anode, active-low,
// one snapshot per scan frame, mode digit blinks for a few frames after a mode change.
module alu_disp_scan #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  input  logic [3:0] result,
  input  logic       zf,
  input  logic       of,
  input  logic       cf,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned      DIV_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       BLINK_LOAD = 4'(BLINK_FRAMES);
  localparam logic [6:0]       SEG_BLANK  = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0] div;
  logic [2:0]       idx;
  logic [2:0]       snap_mode;
  logic [3:0]       snap_result;
  logic             snap_zf;
  logic             snap_of;
  logic             snap_cf;
  logic [3:0]       blink_cnt;

  logic             tick_c;
  logic             load_c;
  logic [2:0]       idx_next_c;
  logic [7:0]       an_next_c;
  logic [6:0]       seg_next_c;
  logic             dp_next_c;
  logic             blink_off_c;
  logic             frame_cf_c;

  assign tick_c      = (div == DIV_LAST);
  assign load_c      = tick_c && (idx == 3'd7);
  assign idx_next_c  = idx + 3'd1;
  assign an_next_c   = ~(8'd1 << idx_next_c);
  assign blink_off_c = (blink_cnt != 4'd0) && blink_cnt[0];
  // Digit 0 is entered on the load tick, so it must show the value being captured
  assign frame_cf_c  = load_c ? cf : snap_cf;

  // Decode the digit that becomes active on this tick
  always_comb begin
    seg_next_c = SEG_BLANK;
    dp_next_c  = 1'b1;
    case (idx_next_c)
      3'd0: seg_next_c = hex7({3'b000, frame_cf_c});
      3'd1: seg_next_c = hex7({3'b000, snap_of});
      3'd2: seg_next_c = hex7({3'b000, snap_zf});
      3'd4: seg_next_c = hex7(snap_result);
      3'd7: begin
        dp_next_c = 1'b0;
        if (!blink_off_c) seg_next_c = hex7({1'b0, snap_mode});
      end
      default: seg_next_c = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      idx         <= 3'd7;
      snap_mode   <= 3'd0;
      snap_result <= 4'd0;
      snap_zf     <= 1'b0;
      snap_of     <= 1'b0;
      snap_cf     <= 1'b0;
      blink_cnt   <= 4'd0;
      an          <= 8'hFF;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
    end else begin
      div <= tick_c ? '0 : div + DIV_W'(1);
      if (tick_c) begin
        idx <= idx_next_c;
        an  <= an_next_c;
        seg <= seg_next_c;
        dp  <= dp_next_c;
      end
      if (load_c) begin
        snap_mode   <= mode;
        snap_result <= result;
        snap_zf     <= zf;
        snap_of     <= of;
        snap_cf     <= cf;
        // Compare against the outgoing snapshot; a change mid-blink restarts the count
        if (mode != snap_mode)
          blink_cnt <= BLINK_LOAD;
        else if (blink_cnt != 4'd0)
          blink_cnt <= blink_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_disp_scan.sv
// Scoreboard bench for alu_disp_scan: a frame-level model queues every expected digit
// with the cycle it should appear; a monitor pops on each display change.
module tb_alu_disp_scan;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned BLINK_FRAMES = 6;
  localparam int unsigned FRAME        = 8 * SCAN_DIV;
  localparam int unsigned N_DIR        = 12;
  localparam logic [15:0] RST_VAL      = {8'hFF, 7'h7F, 1'b1};
  localparam logic [6:0]  SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Directed frames: first-frame pattern, mode change, reload during blink, result=0/zf=1
  localparam logic [2:0] DIR_MODE [N_DIR] = '{3, 3, 4, 4, 6, 6, 6, 6, 6, 6, 6, 6};
  localparam logic [3:0] DIR_RES  [N_DIR] = '{4'hA, 4'h5, 4'hC, 4'h7, 4'h2, 4'h9, 4'hF, 4'h1, 4'hE, 4'h3, 4'h8, 4'h0};
  localparam logic       DIR_ZF   [N_DIR] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1};
  localparam logic       DIR_OF   [N_DIR] = '{1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0};
  localparam logic       DIR_CF   [N_DIR] = '{1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] mode = 3'd0;
  logic [3:0] result = 4'd0;
  logic       zf = 1'b0;
  logic       of = 1'b0;
  logic       cf = 1'b0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  alu_disp_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk(clk), .rst(rst), .mode(mode), .result(result),
    .zf(zf), .of(of), .cf(cf), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc;
  logic [15:0] last = RST_VAL;
  logic        eot = 1'b0;
  logic        eot_done = 1'b0;

  // Model state: mode of the frame currently on display and blink frames remaining
  logic [2:0]  mdl_mode = 3'd0;
  int          mdl_blink = 0;
  int          frame_no = 0;
  logic [2:0]  fr_mode = 3'd0;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // Monitor: reset values while rst is high, one queued entry per display change otherwise
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      #1;
      checks++;
      if ({an, seg, dp} != RST_VAL) begin
        errors++;
        $display("FAIL reset_value got an=%h seg=%h dp=%b want an=ff seg=7f dp=1", an, seg, dp);
      end
      last = RST_VAL;
    end else if (eot) begin
      if (!eot_done) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL sb_drain got %0d pending entries want 0", sb.size());
        end
        eot_done = 1'b1;
      end
    end else if ({an, seg, dp} != last) begin
      last = {an, seg, dp};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d got an=%h seg=%h dp=%b want none", cyc, an, seg, dp);
      end else begin
        mon_e = sb.pop_front();
        if (an !== mon_e.an || seg !== mon_e.seg || dp !== mon_e.dp || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL scan_digit got an=%h seg=%h dp=%b cyc=%0d want an=%h seg=%h dp=%b cyc=%0d",
                   an, seg, dp, cyc, mon_e.an, mon_e.seg, mon_e.dp, mon_e.cyc);
        end
      end
    end
  end

  // Drive one frame's values ahead of the load edge and queue the eight digits it produces
  task automatic load_frame(input int unsigned c);
    logic [2:0] m;
    logic [3:0] r;
    logic       z, o, f;
    logic [7:0] one;
    exp_t       e;
    if (frame_no < N_DIR) begin
      m = DIR_MODE[frame_no]; r = DIR_RES[frame_no];
      z = DIR_ZF[frame_no];   o = DIR_OF[frame_no];  f = DIR_CF[frame_no];
    end else begin
      m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : fr_mode;
      r = 4'($urandom_range(0, 15));
      z = 1'($urandom_range(0, 1)); o = 1'($urandom_range(0, 1)); f = 1'($urandom_range(0, 1));
    end
    frame_no++;
    fr_mode = m;
    mode = m; result = r; zf = z; of = o; cf = f;
    if (m != mdl_mode) mdl_blink = BLINK_FRAMES;
    else if (mdl_blink != 0) mdl_blink--;
    mdl_mode = m;
    one = 8'h01;
    for (int i = 0; i < 8; i++) begin
      e.an  = ~(one << i);
      e.dp  = (i == 7) ? 1'b0 : 1'b1;
      e.cyc = c + 1 + SCAN_DIV * i;
      case (i)
        0: e.seg = SEG_TAB[{3'b000, f}];
        1: e.seg = SEG_TAB[{3'b000, o}];
        2: e.seg = SEG_TAB[{3'b000, z}];
        4: e.seg = SEG_TAB[r];
        7: e.seg = (mdl_blink % 2 == 1) ? 7'h7F : SEG_TAB[{1'b0, m}];
        default: e.seg = 7'h7F;
      endcase
      sb.push_back(e);
    end
  endtask

  // Scan until cycle stop_cyc; inputs are scrambled on every cycle except before a load edge
  task automatic run_until(input int unsigned stop_cyc);
    forever begin
      @(negedge clk);
      if (cyc >= stop_cyc) break;
      if ((cyc + 1) % FRAME == SCAN_DIV) begin
        load_frame(cyc);
      end else begin
        mode = 3'($urandom_range(0, 7)); result = 4'($urandom_range(0, 15));
        zf = 1'($urandom_range(0, 1)); of = 1'($urandom_range(0, 1)); cf = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Stop at idx=4, div=2 of frame 14 and reset asynchronously in mid-slot
    run_until(14 * FRAME + 5 * SCAN_DIV + 2);
    #2;
    rst = 1'b1;
    sb.delete();
    mdl_mode  = 3'd0;
    mdl_blink = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_until(30 * FRAME);
    for (int i = 0; i < 4 * FRAME && sb.size() != 0; i++) @(negedge clk);
    eot = 1'b1;
    for (int i = 0; i < 8 && !eot_done; i++) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
